// File: rtl/lb_sched_pkg.sv
// Shared types and constants for the line-buffer capture scheduler.
package lb_sched_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_TRIG, S_WAIT_BUSY, S_HDR, S_WAIT_DATA,
        S_BURST, S_ROW_END, S_WAIT_IDLE, S_DONE, S_ABORT
    } state_t;

    localparam logic [7:0] HDR_BYTE = 8'hA5;
    localparam int         HDR_LEN  = 3;

    // Header layout: sync byte, row high bits, row low byte.
    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [10:0] row);
        case (idx)
            2'd0:    return HDR_BYTE;
            2'd1:    return {5'b0, row[10:8]};
            default: return row[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lb_sched_ofifo.sv
// Byte+last output FIFO with occupancy count and synchronous flush.
module lb_sched_ofifo #(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        rclk,
    input  logic        rstn,
    input  logic        flush,
    input  logic        wr_en,
    input  logic [7:0]  wr_data,
    input  logic        wr_last,
    input  logic        rd_en,
    output logic [7:0]  rd_data,
    output logic        rd_last,
    output logic [AW:0] count
);

    logic [8:0]    mem [DEPTH];
    logic [AW-1:0] wp, rp;
    logic          do_wr, do_rd;

    assign do_wr = wr_en && (count != (AW+1)'(DEPTH));
    assign do_rd = rd_en && (count != '0);
    assign {rd_last, rd_data} = mem[rp];

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_wr) begin
                mem[wp] <= {wr_last, wr_data};
                wp      <= wp + 1'b1;
            end
            if (do_rd) rp <= rp + 1'b1;
            count <= count + {{AW{1'b0}}, do_wr} - {{AW{1'b0}}, do_rd};
        end
    end

endmodule

// File: rtl/lb_capture_sched.sv
// Round-robin scheduler sharing one line-buffer capture channel between two
// requesters; frames each row with a header and streams it out with backpressure.
module lb_capture_sched
    import lb_sched_pkg::*;
#(
    parameter int H_ACT       = 1280,
    parameter int V_ACT       = 720,
    parameter int BURST       = 16,
    parameter int TIMEOUT     = 2_000_000,
    parameter int OFIFO_DEPTH = 4
) (
    input  logic        rclk,
    input  logic        rstn,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    output logic [1:0]  done,
    output logic        err,
    output logic        lb_trig,
    input  logic        lb_aquire,
    input  logic        lb_busy,
    input  logic        lb_error,
    output logic        lb_read_en,
    input  logic [7:0]  lb_data,
    input  logic [10:0] lb_row,
    output logic        o_valid,
    input  logic        o_ready,
    output logic [7:0]  o_data,
    output logic        o_last,
    output logic        o_id
);

    localparam int BW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam int WW = $clog2(TIMEOUT);
    localparam int CW = $clog2(OFIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BYTE_LAST  = BW'(H_ACT - 1);
    localparam logic [10:0]   ROW_LAST   = 11'(2 * V_ACT - 1);
    localparam logic [6:0]    BURST_LAST = 7'(BURST - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TIMEOUT - 1);
    localparam logic [CW-1:0] FIFO_FULL  = CW'(OFIFO_DEPTH);
    localparam logic [1:0]    HDR_LAST   = 2'(HDR_LEN - 1);

    state_t        state, state_nxt;
    logic          ptr, pick, rd_pend, pend_last;
    logic          hdr_push, wd_run, fifo_room;
    logic [10:0]   row;
    logic [BW-1:0] byte_cnt;
    logic [6:0]    burst_cnt;
    logic [1:0]    hdr_idx;
    logic [WW-1:0] wd;
    logic [CW-1:0] fcount;

    // Reads reserve a FIFO slot while their data is still one cycle away.
    assign fifo_room = (fcount + {{(CW-1){1'b0}}, rd_pend}) < FIFO_FULL;
    assign pick      = ptr ? req[1] : !req[0];
    assign done      = gnt & {2{(state == S_DONE) || (state == S_ABORT)}};
    assign err       = (state == S_ABORT);
    assign o_valid   = (fcount != '0);

    always_comb begin
        state_nxt  = state;
        hdr_push   = 1'b0;
        lb_read_en = 1'b0;
        wd_run     = 1'b0;
        case (state)
            S_IDLE:      if (|req) state_nxt = S_TRIG;
            S_TRIG:      state_nxt = S_WAIT_BUSY;
            S_WAIT_BUSY: begin
                wd_run = 1'b1;
                if (lb_busy) state_nxt = S_HDR;
            end
            S_HDR: begin
                if (fcount != FIFO_FULL) begin
                    hdr_push = 1'b1;
                    if (hdr_idx == HDR_LAST) state_nxt = S_WAIT_DATA;
                end else begin
                    wd_run = 1'b1;
                end
            end
            S_WAIT_DATA: begin
                wd_run = 1'b1;
                if (lb_aquire) state_nxt = S_BURST;
            end
            S_BURST: begin
                if (fifo_room) begin
                    lb_read_en = 1'b1;
                    if (byte_cnt == BYTE_LAST)        state_nxt = S_ROW_END;
                    else if (burst_cnt == BURST_LAST) state_nxt = S_WAIT_DATA;
                end else begin
                    wd_run = 1'b1;
                end
            end
            S_ROW_END:   state_nxt = (row == ROW_LAST) ? S_WAIT_IDLE : S_HDR;
            S_WAIT_IDLE: begin
                wd_run = 1'b1;
                if (!lb_busy && fcount == '0 && !rd_pend) state_nxt = S_DONE;
            end
            default:     state_nxt = S_IDLE;
        endcase
        if (wd_run && wd == WD_LAST) state_nxt = S_ABORT;
        if (lb_error && !(state inside {S_IDLE, S_DONE, S_ABORT})) begin
            state_nxt  = S_ABORT;
            hdr_push   = 1'b0;
            lb_read_en = 1'b0;
        end
    end

    always_ff @(posedge rclk or negedge rstn) begin
        if (!rstn) begin
            state     <= S_IDLE;
            gnt       <= 2'b00;
            ptr       <= 1'b0;
            o_id      <= 1'b0;
            lb_trig   <= 1'b0;
            row       <= '0;
            byte_cnt  <= '0;
            burst_cnt <= '0;
            hdr_idx   <= '0;
            wd        <= '0;
            rd_pend   <= 1'b0;
            pend_last <= 1'b0;
        end else begin
            state     <= state_nxt;
            lb_trig   <= (state == S_TRIG) && (state_nxt == S_WAIT_BUSY);
            rd_pend   <= lb_read_en;
            pend_last <= lb_read_en && (byte_cnt == BYTE_LAST);
            // Watchdog measures consecutive stalled cycles within one state.
            wd        <= (state_nxt != state || !wd_run) ? '0 : wd + 1'b1;
            if (state == S_IDLE && |req) begin
                gnt      <= pick ? 2'b10 : 2'b01;
                o_id     <= pick;
                ptr      <= !pick;
                row      <= '0;
                byte_cnt <= '0;
                hdr_idx  <= '0;
            end
            if (state == S_DONE || state == S_ABORT) gnt <= 2'b00;
            if (hdr_push) hdr_idx <= hdr_idx + 1'b1;
            if (state == S_WAIT_DATA) burst_cnt <= '0;
            if (lb_read_en) begin
                byte_cnt  <= byte_cnt + 1'b1;
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (state == S_ROW_END) begin
                row      <= row + 1'b1;
                byte_cnt <= '0;
                hdr_idx  <= '0;
            end
        end
    end

    lb_sched_ofifo #(.DEPTH(OFIFO_DEPTH)) u_ofifo (
        .rclk    (rclk),
        .rstn    (rstn),
        .flush   (state == S_ABORT),
        .wr_en   (hdr_push || rd_pend),
        .wr_data (hdr_push ? hdr_byte(hdr_idx, row) : lb_data),
        .wr_last (!hdr_push && pend_last),
        .rd_en   (o_valid && o_ready),
        .rd_data (o_data),
        .rd_last (o_last),
        .count   (fcount)
    );

`ifndef SYNTHESIS
    row_match: assert property (@(posedge rclk) disable iff (!rstn)
        (hdr_push && hdr_idx == 2'd0) |-> (lb_row == row));
`endif

endmodule

// File: tb/tb_lb_capture_sched.sv
// Bench for lb_capture_sched: line-buffer stub, stream monitor, scenario tasks.
module tb_lb_capture_sched;

    localparam int H = 8, V = 2, B = 4, TO = 100, D = 4, TOTAL = 2 * V * H, BUD = 3000;

    logic        rclk, rstn;
    logic [1:0]  req, gnt, done;
    logic        err, lb_trig, lb_aquire, lb_busy, lb_error, lb_read_en;
    logic [7:0]  lb_data;
    logic [10:0] lb_row;
    logic        o_valid, o_ready, o_last, o_id;
    logic [7:0]  o_data;

    int n_chk, n_fail, cyc;
    int rd_ptr, produced, busy_dly, rmode;
    bit no_busy;
    logic [7:0] payload [TOTAL];

    logic [9:0] sq[$], exp_q[$];
    logic [1:0] gnt_log[$];
    logic [2:0] done_log[$];
    int trig_cnt, trig_cyc, gnt_cyc, done_cyc, rd_cnt, pay_pop, pkt_idx;
    bit valid_seen;

    lb_capture_sched #(.H_ACT(H), .V_ACT(V), .BURST(B), .TIMEOUT(TO), .OFIFO_DEPTH(D)) dut (
        .rclk(rclk), .rstn(rstn), .req(req), .gnt(gnt), .done(done), .err(err),
        .lb_trig(lb_trig), .lb_aquire(lb_aquire), .lb_busy(lb_busy), .lb_error(lb_error),
        .lb_read_en(lb_read_en), .lb_data(lb_data), .lb_row(lb_row),
        .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_last(o_last), .o_id(o_id)
    );

    initial begin
        rclk = 0;
        forever #5 rclk = ~rclk;
    end

    always @(posedge rclk) cyc <= cyc + 1;

    // Line buffer stub: produces bytes at a random rate, returns reads one cycle later.
    initial begin
        bit rd_s, trig_s;
        lb_busy = 0; lb_aquire = 0; lb_data = 0; lb_row = 0;
        rd_ptr = 0; produced = 0; busy_dly = 0;
        forever begin
            @(negedge rclk);
            rd_s = lb_read_en; trig_s = lb_trig;
            @(posedge rclk); #1;
            if (!rstn) begin
                rd_ptr = 0; produced = 0; busy_dly = 0; lb_busy = 0;
            end else if (trig_s) begin
                rd_ptr = 0; produced = 0; busy_dly = 3; lb_busy = 0;
            end else begin
                if (rd_s) begin
                    lb_data = (rd_ptr < TOTAL) ? payload[rd_ptr] : 8'hEE;
                    rd_ptr++;
                end
                if (busy_dly > 0) begin
                    busy_dly--;
                    if (busy_dly == 0 && !no_busy) lb_busy = 1;
                end
                if (lb_busy && produced < TOTAL && $urandom_range(0, 1) == 1) produced++;
                if (lb_busy && rd_ptr >= TOTAL) lb_busy = 0;
            end
            lb_aquire = (produced - rd_ptr) >= B;
            lb_row    = 11'(rd_ptr / H);
        end
    end

    // Sink ready pattern: always ready, or ready one cycle in three.
    initial begin
        int ph;
        ph = 0; o_ready = 1;
        forever begin
            @(posedge rclk); #1;
            o_ready = (rmode == 0) || (ph == 0);
            ph = (ph + 1) % 3;
        end
    end

    // Stream and event monitor.
    initial begin
        logic [1:0] pg;
        logic [7:0] pd;
        bit pstall, pl;
        pg = 0; pstall = 0; pd = 0; pl = 0;
        forever begin
            @(negedge rclk);
            if (!rstn) begin
                pg = 0; pstall = 0;
            end else begin
                if (gnt != 0 && pg == 0) begin gnt_log.push_back(gnt); gnt_cyc = cyc; end
                pg = gnt;
                if (lb_trig) begin trig_cnt++; trig_cyc = cyc; rd_cnt = 0; pay_pop = 0; pkt_idx = 0; end
                if (done != 0) begin done_log.push_back({err, done}); done_cyc = cyc; end
                if (o_valid) valid_seen = 1;
                if (pstall && o_valid) begin
                    n_chk++;
                    if ({o_last, o_data} !== {pl, pd}) begin
                        n_fail++;
                        $display("FAIL stream_stable: got %b/%h, held value %b/%h", o_last, o_data, pl, pd);
                    end
                end
                if (lb_read_en) begin
                    rd_cnt++;
                    n_chk++;
                    if (rd_cnt - pay_pop > D) begin
                        n_fail++;
                        $display("FAIL read_outstanding: %0d payload bytes outstanding, limit %0d", rd_cnt - pay_pop, D);
                    end
                end
                if (o_valid && o_ready) begin
                    sq.push_back({o_id, o_last, o_data});
                    if (pkt_idx >= 3) pay_pop++;
                    pkt_idx = o_last ? 0 : pkt_idx + 1;
                end
                pstall = o_valid && !o_ready;
                pd = o_data; pl = o_last;
            end
        end
    end

    initial begin
        #500_000;
        $display("FAIL sim_watchdog: simulation did not finish, n_fail=%0d", n_fail);
        $fatal(1);
    end

    function automatic void add_frame(input logic id);
        for (int r = 0; r < 2 * V; r++) begin
            logic [10:0] rw;
            rw = 11'(r);
            exp_q.push_back({id, 1'b0, 8'hA5});
            exp_q.push_back({id, 1'b0, 5'b0, rw[10:8]});
            exp_q.push_back({id, 1'b0, rw[7:0]});
            for (int i = 0; i < H; i++) exp_q.push_back({id, (i == H - 1), payload[r * H + i]});
        end
    endfunction

    task automatic clear_logs();
        sq.delete(); exp_q.delete(); gnt_log.delete(); done_log.delete();
        trig_cnt = 0; valid_seen = 0;
    endtask

    task automatic new_payload();
        for (int i = 0; i < TOTAL; i++) payload[i] = 8'($urandom);
    endtask

    task automatic apply_reset();
        rstn = 0; req = 0; lb_error = 0; no_busy = 0;
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        rstn = 1;
        clear_logs();
    endtask

    task automatic run_until_done(input logic [1:0] stop_on, output bit ok);
        ok = 0;
        for (int i = 0; i < BUD; i++) begin
            @(negedge rclk);
            if ((done & stop_on) != 0) begin ok = 1; req = 0; break; end
        end
        #1;
    endtask

    task automatic test_reset();
        rstn = 1; req = 0; lb_error = 0; no_busy = 0; rmode = 0;
        #2 rstn = 0;
        #1;
        n_chk++;
        if ({gnt, done, err, lb_trig, lb_read_en, o_valid, o_last, o_data, o_id} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b, want all zero",
                     {gnt, done, err, lb_trig, lb_read_en, o_valid, o_last, o_data, o_id});
        end
        apply_reset();
    endtask

    task automatic test_single();
        bit ok;
        apply_reset(); rmode = 0; new_payload();
        req = 2'b01;
        run_until_done(2'b11, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL single_done: no done within %0d cycles", BUD); end
        n_chk++;
        if (gnt_log.size() != 1 || gnt_log[0] !== 2'b01) begin
            n_fail++; $display("FAIL single_gnt: %0d grants, first %b, want 1 grant 01", gnt_log.size(), gnt_log[0]);
        end
        n_chk++;
        if (trig_cnt != 1 || trig_cyc != gnt_cyc + 1) begin
            n_fail++; $display("FAIL single_trig: %0d pulses at cycle %0d, want 1 at %0d", trig_cnt, trig_cyc, gnt_cyc + 1);
        end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 3'b001) begin
            n_fail++; $display("FAIL single_done_pulse: %0d pulses, first %b, want 1 of 001", done_log.size(), done_log[0]);
        end
        add_frame(1'b0);
        n_chk++;
        if (sq.size() != exp_q.size()) begin
            n_fail++; $display("FAIL single_len: %0d bytes, want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (sq[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL single_byte[%0d]: got %h, want %h", i, sq[i], exp_q[i]);
                end
            end
        end
        @(negedge rclk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL single_gnt_clear: gnt %b, want 00", gnt); end
    endtask

    task automatic test_round_robin();
        bit ok;
        apply_reset(); rmode = 0; new_payload();
        req = 2'b11;
        run_until_done(2'b10, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rr_done: second done missing within %0d cycles", BUD); end
        repeat (10) @(negedge rclk);
        #1;
        n_chk++;
        if (gnt_log.size() != 2 || gnt_log[0] !== 2'b01 || gnt_log[1] !== 2'b10) begin
            n_fail++; $display("FAIL rr_gnt_seq: %0d grants %b %b, want 01 then 10", gnt_log.size(), gnt_log[0], gnt_log[1]);
        end
        n_chk++;
        if (done_log.size() != 2 || done_log[0] !== 3'b001 || done_log[1] !== 3'b010) begin
            n_fail++; $display("FAIL rr_done_seq: %0d pulses %b %b, want 001 then 010", done_log.size(), done_log[0], done_log[1]);
        end
        add_frame(1'b0); add_frame(1'b1);
        n_chk++;
        if (sq.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rr_len: %0d bytes, want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (sq[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rr_byte[%0d]: got %h, want %h", i, sq[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        apply_reset(); rmode = 1; new_payload();
        req = 2'b10;
        run_until_done(2'b11, ok);
        rmode = 0;
        n_chk++; if (!ok) begin n_fail++; $display("FAIL bp_done: no done within %0d cycles", BUD); end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 3'b010) begin
            n_fail++; $display("FAIL bp_done_pulse: %0d pulses, first %b, want 1 of 010", done_log.size(), done_log[0]);
        end
        add_frame(1'b1);
        n_chk++;
        if (sq.size() != exp_q.size()) begin
            n_fail++; $display("FAIL bp_len: %0d bytes, want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (sq[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL bp_byte[%0d]: got %h, want %h", i, sq[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        apply_reset(); rmode = 0; no_busy = 1;
        req = 2'b01;
        run_until_done(2'b11, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL to_done: no abort within %0d cycles", BUD); end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 3'b101) begin
            n_fail++; $display("FAIL to_err_done: %0d pulses, first %b, want 1 of 101", done_log.size(), done_log[0]);
        end
        n_chk++;
        if (done_cyc - trig_cyc < TO - 2 || done_cyc - trig_cyc > TO + 2) begin
            n_fail++; $display("FAIL to_latency: abort %0d cycles after trigger, want about %0d", done_cyc - trig_cyc, TO);
        end
        @(negedge rclk);
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL to_gnt_clear: gnt %b, want 00", gnt); end
        n_chk++; if (valid_seen) begin n_fail++; $display("FAIL to_no_valid: o_valid seen 1, want 0"); end
        no_busy = 0;
    endtask

    task automatic test_lb_error();
        bit ok;
        apply_reset(); rmode = 0; new_payload();
        req = 2'b01;
        ok = 0;
        for (int i = 0; i < BUD; i++) begin
            @(posedge rclk); #2;
            if (rd_ptr > H + 2) begin ok = 1; break; end
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL err_reach_row1: row 1 never reached"); end
        lb_error = 1;
        @(negedge rclk);
        n_chk++; if (done !== 2'b00) begin n_fail++; $display("FAIL err_early_done: done %b before abort, want 00", done); end
        @(posedge rclk); #2;
        lb_error = 0;
        @(negedge rclk);
        n_chk++;
        if (done !== 2'b01 || err !== 1'b1) begin
            n_fail++; $display("FAIL err_abort: done %b err %b, want 01 and 1", done, err);
        end
        req = 0;
        @(posedge rclk); #1;
        valid_seen = 0;
        repeat (20) @(negedge rclk);
        #1;
        n_chk++; if (valid_seen) begin n_fail++; $display("FAIL err_flush: o_valid seen after abort, want 0"); end
        n_chk++; if (gnt !== 2'b00) begin n_fail++; $display("FAIL err_gnt_clear: gnt %b, want 00", gnt); end
        clear_logs(); new_payload();
        req = 2'b01;
        run_until_done(2'b11, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL err_recover_done: no done within %0d cycles", BUD); end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 3'b001) begin
            n_fail++; $display("FAIL err_recover_pulse: %0d pulses, first %b, want 1 of 001", done_log.size(), done_log[0]);
        end
        add_frame(1'b0);
        n_chk++;
        if (sq.size() != exp_q.size()) begin
            n_fail++; $display("FAIL err_recover_len: %0d bytes, want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (sq[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL err_recover_byte[%0d]: got %h, want %h", i, sq[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset(); rmode = 0; new_payload();
        req = 2'b10;
        ok = 0;
        for (int i = 0; i < BUD; i++) begin
            @(negedge rclk);
            if (lb_read_en) begin ok = 1; break; end
        end
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_reach_burst: no read seen"); end
        #2 rstn = 0;
        #1;
        n_chk++;
        if ({gnt, done, err, lb_trig, lb_read_en, o_valid, o_last, o_data, o_id} !== '0) begin
            n_fail++; $display("FAIL rst_mid_outputs: got %b, want all zero",
                               {gnt, done, err, lb_trig, lb_read_en, o_valid, o_last, o_data, o_id});
        end
        req = 0;
        repeat (3) @(posedge rclk);
        @(negedge rclk);
        rstn = 1;
        repeat (5) @(negedge rclk);
        #1;
        n_chk++; if (done_log.size() != 0) begin n_fail++; $display("FAIL rst_no_done: %0d done pulses, want 0", done_log.size()); end
        clear_logs(); new_payload();
        req = 2'b10;
        run_until_done(2'b11, ok);
        n_chk++; if (!ok) begin n_fail++; $display("FAIL rst_fresh_done: no done within %0d cycles", BUD); end
        n_chk++;
        if (done_log.size() != 1 || done_log[0] !== 3'b010) begin
            n_fail++; $display("FAIL rst_fresh_pulse: %0d pulses, first %b, want 1 of 010", done_log.size(), done_log[0]);
        end
        add_frame(1'b1);
        n_chk++;
        if (sq.size() != exp_q.size()) begin
            n_fail++; $display("FAIL rst_fresh_len: %0d bytes, want %0d", sq.size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                n_chk++;
                if (sq[i] !== exp_q[i]) begin
                    n_fail++; $display("FAIL rst_fresh_byte[%0d]: got %h, want %h", i, sq[i], exp_q[i]);
                end
            end
        end
    endtask

    initial begin
        n_chk = 0; n_fail = 0; cyc = 0; rmode = 0;
        req = 0; lb_error = 0; no_busy = 0; rstn = 1;
        clear_logs();
        for (int i = 0; i < TOTAL; i++) payload[i] = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_lb_error();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
